gauss_frame_seq: RTL and testbench

Frame sequencer for the 3x3 Gaussian filter stage. On a start command it clears the filter's line state and fetches one frame of 8-bit pixels row by row from a pixel memory. It streams the returned pixels into the filter with programmable inter-line gaps, and counts filter outputs to declare frame completion. It sits between the frame-buffer read port and the filter's `data_in`/`data_valid`/`img_width` inputs.

---
 rtl/gauss_frame_seq_pkg.sv | 18 +
 rtl/gauss_frame_seq_rd_credit_ctr.sv | 37 +++
 rtl/gauss_frame_seq.sv | 199 +++++++++++++++++++
 tb/tb_gauss_frame_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_frame_seq_pkg.sv
// Shared types and constants for the Gaussian-filter frame sequencer.
package gauss_frame_seq_pkg;

    localparam int PIX_W      = 8;   // pixel width
    localparam int DIM_W      = 12;  // width/height field width
    localparam int CLR_CYCLES = 2;   // cycles the filter clear is held low
    localparam int OUT_CNT_W  = 24;  // filter output counter width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_GAP   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/gauss_frame_seq_rd_credit_ctr.sv
// Outstanding-read counter: tracks granted reads not yet returned and
// says whether another request may be issued.
module rd_credit_ctr #(
    parameter int MAX_OUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_issue,
    input  logic       i_return,
    output logic [3:0] o_count,
    output logic       o_can_issue
);

    localparam logic [3:0] MAX_L = 4'(MAX_OUT);

    logic [3:0] r_count;
    logic       w_ret_ok;

    // A return with nothing in flight is a stray and does not count.
    assign w_ret_ok = i_return && (r_count != 4'd0);

    // Issue and return in the same cycle cancel; a slot freed by a return
    // only becomes usable from the following cycle (can_issue is registered-count based).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (i_issue && !w_ret_ok) begin
            r_count <= r_count + 4'd1;
        end else if (!i_issue && w_ret_ok) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_count     = r_count;
    assign o_can_issue = (r_count < MAX_L);

endmodule

// File: rtl/gauss_frame_seq.sv
// Frame sequencer: clears the 3x3 Gaussian filter, fetches one frame
// row by row from pixel memory, streams returns into the filter with
// inter-line gaps and counts filter outputs to detect frame completion.
module gauss_frame_seq
    import gauss_frame_seq_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int MAX_WIDTH = 1024,
    parameter int MAX_OUT   = 4,
    parameter int H_GAP     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DIM_W-1:0]  i_cfg_width,
    input  logic [DIM_W-1:0]  i_cfg_height,
    input  logic [ADDR_W-1:0] i_cfg_base,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cfg_err,
    output logic              o_mem_rd_req,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic              i_mem_rd_gnt,
    input  logic              i_mem_rd_valid,
    input  logic [PIX_W-1:0]  i_mem_rd_data,
    output logic              o_flt_clr_n,
    output logic [DIM_W-1:0]  o_flt_width,
    output logic [PIX_W-1:0]  o_flt_data,
    output logic              o_flt_valid,
    input  logic              i_flt_out_valid,
    output state_t            o_dbg_state
);

    localparam logic [DIM_W:0] MAX_W_L = (DIM_W+1)'(MAX_WIDTH);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [1:0]             r_clr_cnt;
    logic [15:0]            r_gap_cnt;
    logic [DIM_W-1:0]       r_width;
    logic [DIM_W-1:0]       r_height;
    logic [DIM_W-1:0]       r_col;
    logic [DIM_W-1:0]       r_row;
    logic [ADDR_W-1:0]      r_addr;
    logic [OUT_CNT_W-1:0]   r_out_cnt;
    logic                   r_cfg_err;
    logic [PIX_W-1:0]       r_flt_data;
    logic                   r_flt_valid;

    logic                   w_busy;
    logic                   w_done;
    logic                   w_clr_n;
    logic                   w_req;
    logic                   w_grant;
    logic                   w_legal;
    logic                   w_last_col;
    logic                   w_last_row;
    logic                   w_clr_done;
    logic                   w_gap_done;
    logic                   w_out_full;
    logic                   w_drain_done;
    logic                   w_fwd;
    logic [OUT_CNT_W-1:0]   w_exp_out;
    logic [3:0]             w_outst;
    logic                   w_can_issue;

    rd_credit_ctr #(.MAX_OUT(MAX_OUT)) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_issue     (w_grant),
        .i_return    (i_mem_rd_valid),
        .o_count     (w_outst),
        .o_can_issue (w_can_issue)
    );

    assign w_legal      = (i_cfg_width >= 12'd3) && ({1'b0, i_cfg_width} <= MAX_W_L)
                          && (i_cfg_height >= 12'd3);
    assign w_grant      = w_req && i_mem_rd_gnt;
    assign w_last_col   = (r_col == r_width - 12'd1);
    assign w_last_row   = (r_row == r_height - 12'd1);
    assign w_clr_done   = (r_clr_cnt == 2'(CLR_CYCLES - 1));
    assign w_gap_done   = (r_gap_cnt == 16'(H_GAP - 1));
    // A 3x3 filter yields one output per pixel of rows 2..height-1.
    assign w_exp_out    = {12'd0, r_height - 12'd2} * {12'd0, r_width};
    assign w_out_full   = (r_out_cnt == w_exp_out);
    assign w_drain_done = (w_outst == 4'd0) && w_out_full;
    assign w_fwd        = w_busy && i_mem_rd_valid && (w_outst != 4'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start && w_legal) w_next_state = ST_CLEAR;
            ST_CLEAR: if (w_clr_done) w_next_state = ST_FETCH;
            ST_FETCH: begin
                if (w_grant && w_last_col) begin
                    if (w_last_row)      w_next_state = ST_DRAIN;
                    else if (H_GAP == 0) w_next_state = ST_FETCH;
                    else                 w_next_state = ST_GAP;
                end
            end
            ST_GAP:   if (w_gap_done) w_next_state = ST_FETCH;
            ST_DRAIN: if (w_drain_done) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_busy  = (r_state != ST_IDLE);
        w_done  = (r_state == ST_DONE);
        w_clr_n = (r_state != ST_CLEAR);
        w_req   = (r_state == ST_FETCH) && w_can_issue;
    end

    // Configuration latch plus clear, gap, address, row and column counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width   <= '0;
            r_height  <= '0;
            r_addr    <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_clr_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && w_legal) begin
                        r_width   <= i_cfg_width;
                        r_height  <= i_cfg_height;
                        r_addr    <= i_cfg_base;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_clr_cnt <= '0;
                    end
                end
                ST_CLEAR: r_clr_cnt <= r_clr_cnt + 2'd1;
                ST_FETCH: begin
                    r_gap_cnt <= '0;
                    if (w_grant) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + 12'd1;
                        end else begin
                            r_col <= r_col + 12'd1;
                        end
                    end
                end
                ST_GAP:   r_gap_cnt <= r_gap_cnt + 16'd1;
                default:  ;
            endcase
        end
    end

    // Filter output counter; saturates at the expected count so done fires once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_out_cnt <= '0;
        end else if (w_busy && i_flt_out_valid && !w_out_full) begin
            r_out_cnt <= r_out_cnt + 24'd1;
        end
    end

    // Config-error pulse and one-cycle registered forwarding of returns to the filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err   <= 1'b0;
            r_flt_valid <= 1'b0;
            r_flt_data  <= '0;
        end else begin
            r_cfg_err   <= (r_state == ST_IDLE) && i_start && !w_legal;
            r_flt_valid <= w_fwd;
            if (w_fwd) r_flt_data <= i_mem_rd_data;
        end
    end

    assign o_busy        = w_busy;
    assign o_done        = w_done;
    assign o_cfg_err     = r_cfg_err;
    assign o_mem_rd_req  = w_req;
    assign o_mem_rd_addr = r_addr;
    assign o_flt_clr_n   = w_clr_n;
    assign o_flt_width   = r_width;
    assign o_flt_data    = r_flt_data;
    assign o_flt_valid   = r_flt_valid;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_gauss_frame_seq.sv
// Directed bench for gauss_frame_seq with a memory/filter responder.
module tb_gauss_frame_seq;
    import gauss_frame_seq_pkg::*;

    localparam int MAX_OUT = 4;

    typedef struct {
        int         due;
        logic [7:0] data;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] cfg_width = '0;
    logic [11:0] cfg_height = '0;
    logic [19:0] cfg_base = '0;
    logic        mem_rd_gnt = 1'b0;
    logic        mem_rd_valid = 1'b0;
    logic [7:0]  mem_rd_data = '0;
    logic        flt_out_valid = 1'b0;

    logic        o_busy, o_done, o_cfg_err, o_mem_rd_req;
    logic [19:0] o_mem_rd_addr;
    logic        o_flt_clr_n, o_flt_valid;
    logic [11:0] o_flt_width;
    logic [7:0]  o_flt_data;
    state_t      dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // responder / scoreboard state
    int          cyc = 0;
    int          m_w = 4;
    int          m_lat = 2;
    bit          m_rand = 0;
    int          stray_cnt = 0;
    int          outst = 0;
    int          max_outst = 0;
    int          pix_cnt = 0;
    int          outv_cnt = 0;
    int          grants = 0;
    logic [19:0] exp_q[$];
    ret_t        rq[$];
    bit          fwd_exp = 0;
    logic [7:0]  fwd_data_exp = '0;
    bit          track = 0;
    bit          seen_req = 0;
    bit          seen_zero = 0;
    int          zrun = 0;
    int          first_ones = 0;
    int          run_q[$];

    gauss_frame_seq #(
        .ADDR_W(20), .MAX_WIDTH(1024), .MAX_OUT(MAX_OUT), .H_GAP(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_cfg_width    (cfg_width),
        .i_cfg_height   (cfg_height),
        .i_cfg_base     (cfg_base),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_cfg_err      (o_cfg_err),
        .o_mem_rd_req   (o_mem_rd_req),
        .o_mem_rd_addr  (o_mem_rd_addr),
        .i_mem_rd_gnt   (mem_rd_gnt),
        .i_mem_rd_valid (mem_rd_valid),
        .i_mem_rd_data  (mem_rd_data),
        .o_flt_clr_n    (o_flt_clr_n),
        .o_flt_width    (o_flt_width),
        .o_flt_data     (o_flt_data),
        .o_flt_valid    (o_flt_valid),
        .i_flt_out_valid(flt_out_valid),
        .o_dbg_state    (dbg_state)
    );

    // clock
    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder, return pipeline, zero-latency filter model and
    // per-cycle checks of credit limit, address order and forwarding.
    initial begin : mem_model
        bit         ret;
        bit         g;
        bit         inc;
        logic [7:0] rdata;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rq.delete();
                exp_q.delete();
                outst         = 0;
                fwd_exp       = 0;
                mem_rd_gnt    = 1'b0;
                mem_rd_valid  = 1'b0;
                mem_rd_data   = '0;
                flt_out_valid = 1'b0;
            end else begin
                chk("fwd_valid", o_flt_valid, fwd_exp);
                if (fwd_exp) chk("fwd_data", o_flt_data, fwd_data_exp);
                flt_out_valid = 1'b0;
                if (o_flt_valid) begin
                    if (pix_cnt >= 2 * m_w) begin
                        flt_out_valid = 1'b1;
                        outv_cnt++;
                    end
                    pix_cnt++;
                end
                if (o_mem_rd_req) chk("credit_limit", outst < MAX_OUT, 1);
                if (track) begin
                    if (o_mem_rd_req) begin
                        if (!seen_zero) first_ones++;
                        if (seen_req && zrun > 0) run_q.push_back(zrun);
                        seen_req = 1;
                        zrun = 0;
                    end else if (seen_req) begin
                        zrun++;
                        seen_zero = 1;
                    end
                end
                ret   = 0;
                rdata = '0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    ret   = 1;
                    rdata = rq[0].data;
                    void'(rq.pop_front());
                end else if (stray_cnt > 0) begin
                    ret   = 1;
                    rdata = 8'hEE;
                    stray_cnt--;
                end
                mem_rd_valid = ret;
                mem_rd_data  = rdata;
                fwd_exp      = ret && (outst > 0);
                fwd_data_exp = rdata;
                g = m_rand ? bit'($urandom_range(0, 1)) : 1'b1;
                mem_rd_gnt = g;
                inc = o_mem_rd_req && g;
                if (inc) begin
                    if (exp_q.size() == 0) chk("addr_extra", exp_q.size(), 1);
                    else chk("addr", o_mem_rd_addr, exp_q.pop_front());
                    rq.push_back('{due: cyc + m_lat, data: o_mem_rd_addr[7:0]});
                    grants++;
                end
                outst = outst + int'(inc) - int'(fwd_exp);
                if (outst > max_outst) max_outst = outst;
            end
        end
    end

    task automatic start_frame(input int w, input int h, input logic [19:0] base,
                               input int lat, input bit rnd);
        @(negedge clk);
        m_w = w; m_lat = lat; m_rand = rnd;
        pix_cnt = 0; outv_cnt = 0; grants = 0; max_outst = 0;
        exp_q.delete();
        for (int i = 0; i < w * h; i++) exp_q.push_back(base + 20'(i));
        run_q.delete();
        track = 1; seen_req = 0; seen_zero = 0; zrun = 0; first_ones = 0;
        cfg_width = 12'(w); cfg_height = 12'(h); cfg_base = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_outs);
        bit got;
        int extra;
        got = 0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (o_done) got = 1;
        end
        chk({tag, "_done_seen"}, got, 1);
        if (got) begin
            track = 0;
            chk({tag, "_busy_at_done"}, o_busy, 1);
            chk({tag, "_outputs"}, outv_cnt, exp_outs);
            chk({tag, "_addr_left"}, exp_q.size(), 0);
            @(negedge clk);
            chk({tag, "_busy_after"}, o_busy, 0);
            extra = 0;
            for (int n = 0; n < 4; n++) begin
                if (o_done) extra++;
                @(negedge clk);
            end
            chk({tag, "_done_once"}, extra, 0);
        end
    endtask

    task automatic illegal(input string tag, input int w, input int h);
        @(negedge clk);
        cfg_width = 12'(w); cfg_height = 12'(h); cfg_base = 20'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_err"}, o_cfg_err, 1);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_req"}, o_mem_rd_req, 0);
        chk({tag, "_clr_n"}, o_flt_clr_n, 1);
        @(negedge clk);
        chk({tag, "_err_off"}, o_cfg_err, 0);
        chk({tag, "_busy2"}, o_busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_cfg_err"}, o_cfg_err, 0);
        chk({tag, "_req"}, o_mem_rd_req, 0);
        chk({tag, "_addr"}, o_mem_rd_addr, 0);
        chk({tag, "_clr_n"}, o_flt_clr_n, 1);
        chk({tag, "_width"}, o_flt_width, 0);
        chk({tag, "_fdata"}, o_flt_data, 0);
        chk({tag, "_fvalid"}, o_flt_valid, 0);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    initial begin : main
        // reset
        repeat (2) @(negedge clk);
        check_reset_values("por");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // basic frame: width 4, height 3, base 0x100, latency 2
        start_frame(4, 3, 20'h00100, 2, 0);
        chk("t1_busy", o_busy, 1);
        chk("t1_clr_n", o_flt_clr_n, 0);
        chk("t1_width", o_flt_width, 4);
        chk("t1_req", o_mem_rd_req, 0);
        @(negedge clk);
        chk("t2_clr_n", o_flt_clr_n, 0);
        chk("t2_req", o_mem_rd_req, 0);
        @(negedge clk);
        chk("t3_clr_n", o_flt_clr_n, 1);
        chk("t3_req", o_mem_rd_req, 1);
        chk("t3_addr", o_mem_rd_addr, 20'h00100);
        wait_done("basic", 4);
        chk("basic_reads", grants, 12);

        // illegal configurations
        illegal("ill_w2", 2, 5);
        illegal("ill_h2", 5, 2);
        illegal("ill_w1025", 1025, 5);

        // credit limit: latency 10
        start_frame(8, 3, 20'h01000, 10, 0);
        wait_done("credit", 8);
        chk("credit_max", max_outst, 4);
        chk("credit_burst", first_ones, 4);
        chk("credit_stall", (run_q.size() > 0) ? run_q[0] : -1, 7);

        // gaps with random grant, latency 1
        start_frame(8, 4, 20'h04000, 1, 1);
        wait_done("gap", 16);
        chk("gap_runs", run_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("gap_run%0d", i), (i < run_q.size()) ? run_q[i] : -1, 4);

        // reset during row 1
        start_frame(4, 4, 20'h00200, 2, 0);
        for (int n = 0; n < 300 && grants < 6; n++) @(negedge clk);
        chk("rst_in_row1", grants >= 6, 1);
        #1 rst_n = 1'b0;
        #1 check_reset_values("mid_rst");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        stray_cnt = 2;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("stray_fwd", o_flt_valid, 0);
        end
        chk("stray_state", dbg_state, ST_IDLE);
        start_frame(4, 4, 20'h00300, 2, 0);
        wait_done("post_rst", 8);

        // busy overlap, simultaneous grant/return, address wrap
        start_frame(6, 3, 20'hFFFF8, 3, 0);
        for (int n = 0; n < 300 && grants < 3; n++) @(negedge clk);
        cfg_width = 12'd10; cfg_height = 12'd9; cfg_base = 20'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ovl_width", o_flt_width, 6);
        chk("ovl_cfg_err", o_cfg_err, 0);
        chk("ovl_busy", o_busy, 1);
        wait_done("overlap", 6);
        chk("ovl_runs", run_q.size(), 2);
        for (int i = 0; i < 2; i++)
            chk($sformatf("ovl_run%0d", i), (i < run_q.size()) ? run_q[i] : -1, 4);
        chk("ovl_width_after", o_flt_width, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
